fmac_eac_adder_pipe: RTL and testbench
======================================

Name: fmac_eac_adder_pipe

Overview:
- Parametrised, pipelined successor of the FMA adder stage.
- Merges the multiplier's carry-save pair with the aligned addend high part, resolves the end-around sign, and emits positive magnitude, result sign and sticky to the LZA/normaliser.
- Differs from the single-cycle stage in four ways: generic mantissa width, 1- or 2-cycle latency, valid/ready handshake with back-pressure, and a tag/flush path.

Parameters:
- C_MANT, 23, mantissa width without hidden bit; W_L = 2*C_MANT+2, W_H = C_MANT+4, W_O = 3*C_MANT+5.
- LATENCY, 2, pipeline depth, 1 or 2; any other value is an elaboration error.
- TAG_WIDTH, 4, opaque per-operation tag carried alongside data.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset.
- In_Valid_SI  in  1  input operation valid.
- In_Ready_SO  out  1  stage accepts input.
- Tag_DI  in  TAG_WIDTH  operation tag.
- AL_DI  in  W_L  carry-save sum word.
- BL_DI  in  W_L  carry-save carry word.
- BH_DI  in  W_H  aligned addend high part (pre-inverted when subtracting).
- Sub_SI  in  1  effective subtraction.
- Sign_postalig_DI  in  1  sign of addend after alignment.
- Sign_amt_SI  in  1  addend dominates, product below sticky range.
- Sft_stop_SI  in  1  product dominates, addend fully shifted out.
- Prod_special_SI  in  1  b or c is zero, inf or NaN.
- Flush_SI  in  1  kill all in-flight operations.
- Out_Valid_SO  out  1  output valid.
- Out_Ready_SI  in  1  consumer accepts output.
- Sum_pos_DO  out  W_O  positive magnitude.
- Sign_out_DO  out  1  result sign.
- Sign_change_SO  out  1  negation performed.
- Sticky_SO  out  1  sticky contribution.
- Tag_DO  out  TAG_WIDTH  tag of output operation.
- Busy_SO  out  1  any stage holds a valid operation.

Behaviour:
- Arithmetic for the normal path (Sign_amt=0, Sft_stop=0):
  - V = ({BH, W_L zeros} + AL + BL + Sub) mod 2^(W_H+W_L).
  - N = V[W_H+W_L-1].
  - Sum_pos = N ? (2^(W_H+W_L) - V)[W_O-1:0] : V[W_O-1:0].
  - Sign_out = N ^ Sign_postalig; Sign_change = N.
- Sft_stop=1 (checked first):
  - Sum_pos = zero-extended (AL + BL + Sub)[W_L-1:0].
  - Sign_out and Sign_change as in the normal path.
- Sign_amt=1 and Sft_stop=0:
  - P = ~Prod_special & Sub.
  - Sum_pos = (({BH[W_H-2:0],1'b0} - P) << (W_L-1)) truncated to W_O.
  - Sign_out = Sign_postalig; Sign_change = 0.
- Sticky = Sign_amt ? (~Prod_special & Sub) : ~Prod_special.
- LATENCY=1:
  - Inputs are registered once; all arithmetic is combinational ahead of the output register.
- LATENCY=2:
  - Stage 1 registers the low sum, low carry-out, BH, control bits and tag.
  - Stage 2 performs the high incrementer/decrementer, negation select, bypass muxing, and registers the outputs.
- Handshake:
  - Transfer occurs when Valid & Ready are both high in the same cycle.
  - Each stage advances when it is empty or its downstream accepts.
  - In_Ready_SO = ~stage1_valid | stage1_advance; it is combinational from Out_Ready_SI.
  - Full throughput: one operation per cycle while Out_Ready=1.
- Output stability: while Out_Valid=1 and Out_Ready=0, Sum_pos/Sign/Sticky/Tag hold stable and no stage drops data.
- Ordering: operations exit in input order.
- Flush_SI:
  - Clears all stage valids at the next edge.
  - An input presented in the same cycle is discarded.
  - In_Ready=1 in the following cycle.
- Reset (any cycle, including mid-operation):
  - All valids clear to 0; Out_Valid=0, Busy=0.
  - Sum_pos=0, Sign_out=0, Sign_change=0, Sticky=0, Tag_DO=0.
  - In_Ready=1 in the first cycle after reset.
- Sign_amt and Sft_stop both 1: Sft_stop wins.
- Datapath registers update only on stage advance; registers of empty stages hold.

Test Plan:
- Plain add, C_MANT=23, LATENCY=2: AL=5, BL=3, BH=0, Sub=0, Sign_postalig=1, Prod_special=0 -> after 2 cycles Out_Valid=1, Sum_pos=8, Sign_out=1, Sign_change=0, Sticky=1.
- Negation: AL=0, BL=0, BH=27'h7FFFFFF, Sub=0, Sign_postalig=0 -> Sum_pos=1<<48, Sign_change=1, Sign_out=1.
- Addend-dominates subtract: Sign_amt=1, Sub=1, BH=4, Prod_special=0 -> Sum_pos=7<<47, Sign_change=0, Sticky=1; repeat with Prod_special=1 -> Sum_pos=8<<47, Sticky=0.
- Back-pressure: Out_Ready=0, issue 3 ops with tags 1,2,3 -> tags 1,2 accepted, In_Ready=0 on third. Release Out_Ready -> tags emerge 1,2,3 in order, outputs stable while stalled.
- Throughput/LATENCY=1: 10 back-to-back ops with Out_Ready=1 -> 10 outputs on consecutive cycles, each one cycle after input.
- Flush and reset mid-op: 2 ops in flight, assert Flush_SI -> next cycle Out_Valid=0, Busy=0, no tags emitted. Repeat with Rst_RI -> all outputs 0.

Source files
------------

// File: rtl/fmac_eac_adder_pipe_if.sv
// rtl/fmac_eac_adder_pipe_if.sv - operation/result handshake channels of the EAC adder pipe
interface fmac_eac_adder_pipe_if #(
  parameter int C_MANT    = 23,
  parameter int TAG_WIDTH = 4
);
  localparam int W_L = 2*C_MANT+2;
  localparam int W_H = C_MANT+4;
  localparam int W_O = 3*C_MANT+5;

  logic                 In_Valid_SI;
  logic                 In_Ready_SO;
  logic [TAG_WIDTH-1:0] Tag_DI;
  logic [W_L-1:0]       AL_DI;
  logic [W_L-1:0]       BL_DI;
  logic [W_H-1:0]       BH_DI;
  logic                 Sub_SI;
  logic                 Sign_postalig_DI;
  logic                 Sign_amt_SI;
  logic                 Sft_stop_SI;
  logic                 Prod_special_SI;
  logic                 Flush_SI;
  logic                 Out_Valid_SO;
  logic                 Out_Ready_SI;
  logic [W_O-1:0]       Sum_pos_DO;
  logic                 Sign_out_DO;
  logic                 Sign_change_SO;
  logic                 Sticky_SO;
  logic [TAG_WIDTH-1:0] Tag_DO;
  logic                 Busy_SO;

  modport master (
    output In_Valid_SI, Tag_DI, AL_DI, BL_DI, BH_DI, Sub_SI, Sign_postalig_DI,
           Sign_amt_SI, Sft_stop_SI, Prod_special_SI, Flush_SI, Out_Ready_SI,
    input  In_Ready_SO, Out_Valid_SO, Sum_pos_DO, Sign_out_DO, Sign_change_SO,
           Sticky_SO, Tag_DO, Busy_SO
  );

  modport slave (
    input  In_Valid_SI, Tag_DI, AL_DI, BL_DI, BH_DI, Sub_SI, Sign_postalig_DI,
           Sign_amt_SI, Sft_stop_SI, Prod_special_SI, Flush_SI, Out_Ready_SI,
    output In_Ready_SO, Out_Valid_SO, Sum_pos_DO, Sign_out_DO, Sign_change_SO,
           Sticky_SO, Tag_DO, Busy_SO
  );
endinterface

// File: rtl/fmac_eac_adder_pipe.sv
// rtl/fmac_eac_adder_pipe.sv - pipelined FMA end-around-carry adder stage with valid/ready and flush
module fmac_eac_adder_pipe #(
  parameter int C_MANT    = 23,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 4
) (
  input logic                  Clk_CI,
  input logic                  Rst_RI,
  fmac_eac_adder_pipe_if.slave bus
);
  localparam int W_L = 2*C_MANT+2;
  localparam int W_H = C_MANT+4;
  localparam int W_O = 3*C_MANT+5;
  localparam int W_V = W_H+W_L;

  typedef struct packed {
    logic [W_L-1:0]       low;
    logic                 cout;
    logic [W_H-1:0]       bh;
    logic                 sign_postalig;
    logic                 sign_amt;
    logic                 sft_stop;
    logic                 p;
    logic                 sticky;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  s1_t                  s1_d;
  s1_t                  s1_x;
  logic [W_L:0]         low_full;
  logic                 in_ready;
  logic                 feed;
  logic                 stage1_busy;
  logic                 out_adv;
  logic                 out_valid;
  logic [W_O-1:0]       sum_q;
  logic                 sign_q;
  logic                 chg_q;
  logic                 sticky_q;
  logic [TAG_WIDTH-1:0] tag_q;

  assign low_full = {1'b0, bus.AL_DI} + {1'b0, bus.BL_DI} + {{W_L{1'b0}}, bus.Sub_SI};

  always_comb begin
    s1_d               = '0;
    s1_d.low           = low_full[W_L-1:0];
    s1_d.cout          = low_full[W_L];
    s1_d.bh            = bus.BH_DI;
    s1_d.sign_postalig = bus.Sign_postalig_DI;
    s1_d.sign_amt      = bus.Sign_amt_SI;
    s1_d.sft_stop      = bus.Sft_stop_SI;
    s1_d.p             = ~bus.Prod_special_SI & bus.Sub_SI;
    s1_d.sticky        = bus.Sign_amt_SI ? (~bus.Prod_special_SI & bus.Sub_SI) : ~bus.Prod_special_SI;
    s1_d.tag           = bus.Tag_DI;
  end

  // High-part incrementer and end-around sign resolution
  logic [W_H-1:0] high;
  logic [W_H-1:0] amt_mant;
  logic [W_V-1:0] v;
  logic [W_O-1:0] v_neg;
  logic           n;
  logic [W_O-1:0] res_sum;
  logic           res_sign;
  logic           res_chg;

  assign high     = s1_x.bh + {{(W_H-1){1'b0}}, s1_x.cout};
  assign v        = {high, s1_x.low};
  assign v_neg    = -v[W_O-1:0];
  assign n        = v[W_V-1];
  assign amt_mant = {s1_x.bh[W_H-2:0], 1'b0} - {{(W_H-1){1'b0}}, s1_x.p};

  always_comb begin
    res_sum  = n ? v_neg : v[W_O-1:0];
    res_sign = n ^ s1_x.sign_postalig;
    res_chg  = n;
    if (s1_x.sft_stop) begin
      res_sum = {{(W_O-W_L){1'b0}}, s1_x.low};
    end else if (s1_x.sign_amt) begin
      res_sum  = {amt_mant, {(W_L-1){1'b0}}};
      res_sign = s1_x.sign_postalig;
      res_chg  = 1'b0;
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      s1_t  s1_q;
      logic v1;
      always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
          v1   <= 1'b0;
          s1_q <= '0;
        end else if (bus.Flush_SI) begin
          v1 <= 1'b0;
        end else if (in_ready) begin
          v1 <= bus.In_Valid_SI;
          if (bus.In_Valid_SI) s1_q <= s1_d;
        end
      end
      assign in_ready    = ~v1 | out_adv;
      assign feed        = v1;
      assign stage1_busy = v1;
      assign s1_x        = s1_q;
    end else if (LATENCY == 1) begin : g_lat1
      assign in_ready    = out_adv;
      assign feed        = bus.In_Valid_SI;
      assign stage1_busy = 1'b0;
      assign s1_x        = s1_d;
    end else begin : g_bad_latency
      $error("fmac_eac_adder_pipe: LATENCY must be 1 or 2");
    end
  endgenerate

  assign out_adv = ~out_valid | bus.Out_Ready_SI;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      out_valid <= 1'b0;
      sum_q     <= '0;
      sign_q    <= 1'b0;
      chg_q     <= 1'b0;
      sticky_q  <= 1'b0;
      tag_q     <= '0;
    end else if (bus.Flush_SI) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= feed;
      if (feed) begin
        sum_q    <= res_sum;
        sign_q   <= res_sign;
        chg_q    <= res_chg;
        sticky_q <= s1_x.sticky;
        tag_q    <= s1_x.tag;
      end
    end
  end

  assign bus.In_Ready_SO    = in_ready;
  assign bus.Out_Valid_SO   = out_valid;
  assign bus.Sum_pos_DO     = sum_q;
  assign bus.Sign_out_DO    = sign_q;
  assign bus.Sign_change_SO = chg_q;
  assign bus.Sticky_SO      = sticky_q;
  assign bus.Tag_DO         = tag_q;
  assign bus.Busy_SO        = stage1_busy | out_valid;
endmodule

// File: tb/tb_fmac_eac_adder_pipe.sv
// tb/tb_fmac_eac_adder_pipe.sv - scoreboard bench for the EAC adder pipe, LATENCY 2 and 1 instances
module tb_fmac_eac_adder_pipe;
  localparam int C_MANT = 23;
  localparam int W_L = 2*C_MANT+2;
  localparam int W_H = C_MANT+4;
  localparam int W_O = 3*C_MANT+5;
  localparam int W_V = W_H+W_L;

  typedef struct {
    logic [W_O-1:0] sum;
    logic           sign;
    logic           chg;
    logic           sticky;
    logic [3:0]     tag;
    int             cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;
  logic lat_chk;
  logic fired2;
  logic fired1;
  exp_t pend2;
  exp_t pend1;
  exp_t q2[$];
  exp_t q1[$];

  fmac_eac_adder_pipe_if #(.C_MANT(C_MANT), .TAG_WIDTH(4)) bus2 ();
  fmac_eac_adder_pipe_if #(.C_MANT(C_MANT), .TAG_WIDTH(4)) bus1 ();

  fmac_eac_adder_pipe #(.C_MANT(C_MANT), .LATENCY(2), .TAG_WIDTH(4)) dut2 (
    .Clk_CI(clk), .Rst_RI(rst), .bus(bus2)
  );
  fmac_eac_adder_pipe #(.C_MANT(C_MANT), .LATENCY(1), .TAG_WIDTH(4)) dut1 (
    .Clk_CI(clk), .Rst_RI(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W_L-1:0] al, input logic [W_L-1:0] bl,
                                 input logic [W_H-1:0] bh, input logic sub, input logic sp,
                                 input logic samt, input logic sstop, input logic ps,
                                 input logic [3:0] tag);
    exp_t           r;
    logic [W_V-1:0] vv;
    logic [W_V:0]   mag;
    logic [W_V-1:0] lo;
    logic [W_H-1:0] m;
    logic           nn;
    vv = {bh, {W_L{1'b0}}} + {{W_H{1'b0}}, al} + {{W_H{1'b0}}, bl} + {{(W_V-1){1'b0}}, sub};
    nn = vv[W_V-1];
    mag = nn ? ({1'b1, {W_V{1'b0}}} - {1'b0, vv}) : {1'b0, vv};
    r.sum = mag[W_O-1:0];
    r.sign = nn ^ sp;
    r.chg = nn;
    if (sstop) begin
      lo = {{W_H{1'b0}}, al} + {{W_H{1'b0}}, bl} + {{(W_V-1){1'b0}}, sub};
      r.sum = {{(W_O-W_L){1'b0}}, lo[W_L-1:0]};
    end else if (samt) begin
      m = {bh[W_H-2:0], 1'b0} - {{(W_H-1){1'b0}}, (~ps & sub)};
      r.sum = {{(W_O-W_H){1'b0}}, m} << (W_L-1);
      r.sign = sp;
      r.chg = 1'b0;
    end
    r.sticky = samt ? (~ps & sub) : ~ps;
    r.tag = tag;
    r.cyc = 0;
    return r;
  endfunction

  task automatic drive2(input logic [W_L-1:0] al, input logic [W_L-1:0] bl, input logic [W_H-1:0] bh,
                        input logic sub, input logic sp, input logic samt, input logic sstop,
                        input logic ps, input logic [3:0] tag);
    bus2.AL_DI = al; bus2.BL_DI = bl; bus2.BH_DI = bh; bus2.Sub_SI = sub;
    bus2.Sign_postalig_DI = sp; bus2.Sign_amt_SI = samt; bus2.Sft_stop_SI = sstop;
    bus2.Prod_special_SI = ps; bus2.Tag_DI = tag; bus2.In_Valid_SI = 1'b1;
    pend2 = model(al, bl, bh, sub, sp, samt, sstop, ps, tag);
  endtask

  task automatic drive1(input logic [W_L-1:0] al, input logic [W_L-1:0] bl, input logic [W_H-1:0] bh,
                        input logic sub, input logic sp, input logic samt, input logic sstop,
                        input logic ps, input logic [3:0] tag);
    bus1.AL_DI = al; bus1.BL_DI = bl; bus1.BH_DI = bh; bus1.Sub_SI = sub;
    bus1.Sign_postalig_DI = sp; bus1.Sign_amt_SI = samt; bus1.Sft_stop_SI = sstop;
    bus1.Prod_special_SI = ps; bus1.Tag_DI = tag; bus1.In_Valid_SI = 1'b1;
    pend1 = model(al, bl, bh, sub, sp, samt, sstop, ps, tag);
  endtask

  task automatic expect2(input logic [W_O-1:0] s, input logic sg, input logic ch, input logic st);
    pend2.sum = s; pend2.sign = sg; pend2.chg = ch; pend2.sticky = st;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    fired2 = 1'b0;
    fired1 = 1'b0;
    if (!rst && !bus2.Flush_SI && bus2.Out_Valid_SO && bus2.Out_Ready_SI) begin
      if (q2.size() == 0) chk("l2_spurious_out", bus2.Out_Valid_SO, 0);
      else begin
        e = q2.pop_front();
        chk("l2_sum", bus2.Sum_pos_DO, e.sum);
        chk("l2_sign", bus2.Sign_out_DO, e.sign);
        chk("l2_chg", bus2.Sign_change_SO, e.chg);
        chk("l2_sticky", bus2.Sticky_SO, e.sticky);
        chk("l2_tag", bus2.Tag_DO, e.tag);
        if (lat_chk) chk("l2_latency", cyc - e.cyc, 2);
      end
    end
    if (!rst && !bus2.Flush_SI && bus2.In_Valid_SI && bus2.In_Ready_SO) begin
      pend2.cyc = cyc; q2.push_back(pend2); fired2 = 1'b1;
    end
    if (rst || bus2.Flush_SI) q2.delete();
    if (!rst && !bus1.Flush_SI && bus1.Out_Valid_SO && bus1.Out_Ready_SI) begin
      if (q1.size() == 0) chk("l1_spurious_out", bus1.Out_Valid_SO, 0);
      else begin
        e = q1.pop_front();
        chk("l1_sum", bus1.Sum_pos_DO, e.sum);
        chk("l1_sign", bus1.Sign_out_DO, e.sign);
        chk("l1_chg", bus1.Sign_change_SO, e.chg);
        chk("l1_sticky", bus1.Sticky_SO, e.sticky);
        chk("l1_tag", bus1.Tag_DO, e.tag);
        if (lat_chk) chk("l1_latency", cyc - e.cyc, 1);
      end
    end
    if (!rst && !bus1.Flush_SI && bus1.In_Valid_SI && bus1.In_Ready_SO) begin
      pend1.cyc = cyc; q1.push_back(pend1); fired1 = 1'b1;
    end
    if (rst || bus1.Flush_SI) q1.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (q2.size() + q1.size()) != 0; i++) tick();
    chk("drain_empty", q2.size() + q1.size(), 0);
  endtask

  task automatic check_zero2(input string pfx);
    chk({pfx, "_out_valid"}, bus2.Out_Valid_SO, 0);
    chk({pfx, "_busy"}, bus2.Busy_SO, 0);
    chk({pfx, "_in_ready"}, bus2.In_Ready_SO, 1);
    chk({pfx, "_sum"}, bus2.Sum_pos_DO, 0);
    chk({pfx, "_sign"}, bus2.Sign_out_DO, 0);
    chk({pfx, "_chg"}, bus2.Sign_change_SO, 0);
    chk({pfx, "_sticky"}, bus2.Sticky_SO, 0);
    chk({pfx, "_tag"}, bus2.Tag_DO, 0);
  endtask

  initial begin
    logic [63:0] r64;
    logic [63:0] r64b;
    logic [31:0] r32;
    vectors = 0; miscompares = 0; cyc = 0; lat_chk = 1'b0;
    fired2 = 1'b0; fired1 = 1'b0;
    rst = 1'b1;
    bus2.In_Valid_SI = 0; bus2.Tag_DI = 0; bus2.AL_DI = 0; bus2.BL_DI = 0; bus2.BH_DI = 0;
    bus2.Sub_SI = 0; bus2.Sign_postalig_DI = 0; bus2.Sign_amt_SI = 0; bus2.Sft_stop_SI = 0;
    bus2.Prod_special_SI = 0; bus2.Flush_SI = 0; bus2.Out_Ready_SI = 0;
    bus1.In_Valid_SI = 0; bus1.Tag_DI = 0; bus1.AL_DI = 0; bus1.BL_DI = 0; bus1.BH_DI = 0;
    bus1.Sub_SI = 0; bus1.Sign_postalig_DI = 0; bus1.Sign_amt_SI = 0; bus1.Sft_stop_SI = 0;
    bus1.Prod_special_SI = 0; bus1.Flush_SI = 0; bus1.Out_Ready_SI = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_zero2("reset");
    chk("reset_l1_in_ready", bus1.In_Ready_SO, 1);

    // plain add, two-cycle latency
    lat_chk = 1'b1;
    bus2.Out_Ready_SI = 1'b1;
    drive2(48'd5, 48'd3, 27'd0, 0, 1, 0, 0, 0, 4'd5);
    expect2(74'd8, 1'b1, 1'b0, 1'b1);
    tick();
    bus2.In_Valid_SI = 1'b0;
    chk("add_not_yet_valid", bus2.Out_Valid_SO, 0);
    chk("add_busy", bus2.Busy_SO, 1);
    tick();
    chk("add_valid_after_2", bus2.Out_Valid_SO, 1);
    tick();

    // negation, addend-dominates with and without special product, sft_stop priority
    drive2(48'd0, 48'd0, 27'h7FFFFFF, 0, 0, 0, 0, 0, 4'd6);
    expect2(74'h1 << 48, 1'b1, 1'b1, 1'b1);
    tick();
    drive2(48'd0, 48'd0, 27'd4, 1, 0, 1, 0, 0, 4'd7);
    expect2(74'd7 << 47, 1'b0, 1'b0, 1'b1);
    tick();
    drive2(48'd0, 48'd0, 27'd4, 1, 0, 1, 0, 1, 4'd8);
    expect2(74'd8 << 47, 1'b0, 1'b0, 1'b0);
    tick();
    drive2(48'hFFFF_FFFF_FFFF, 48'd1, 27'd0, 1, 0, 1, 1, 0, 4'd9);
    expect2(74'd1, 1'b0, 1'b0, 1'b1);
    tick();
    bus2.In_Valid_SI = 1'b0;
    drain(6);

    // back-pressure: third op refused, stalled output holds, order preserved
    lat_chk = 1'b0;
    bus2.Out_Ready_SI = 1'b0;
    drive2(48'd100, 48'd1, 27'd0, 0, 0, 0, 0, 0, 4'd1);
    #1 chk("bp_ready_1", bus2.In_Ready_SO, 1);
    tick();
    drive2(48'd200, 48'd2, 27'd0, 0, 1, 0, 0, 0, 4'd2);
    #1 chk("bp_ready_2", bus2.In_Ready_SO, 1);
    tick();
    drive2(48'd300, 48'd3, 27'h7FFFFF0, 1, 0, 0, 0, 0, 4'd3);
    #1 chk("bp_ready_3", bus2.In_Ready_SO, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_valid", bus2.Out_Valid_SO, 1);
      chk("bp_stall_tag", bus2.Tag_DO, 1);
      chk("bp_stall_sum", bus2.Sum_pos_DO, q2[0].sum);
    end
    bus2.Out_Ready_SI = 1'b1;
    for (int i = 0; i < 8 && bus2.In_Valid_SI; i++) begin
      tick();
      if (fired2) bus2.In_Valid_SI = 1'b0;
    end
    chk("bp_tag3_accepted", bus2.In_Valid_SI, 0);
    drain(8);

    // random traffic with random back-pressure
    for (int k = 0; k < 24; k++) begin
      r64 = {$urandom(), $urandom()};
      r64b = {$urandom(), $urandom()};
      r32 = $urandom();
      drive2(r64[W_L-1:0], r64b[W_L-1:0], r32[W_H-1:0], r32[27], r32[28],
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), r32[29], 4'(k));
      for (int i = 0; i < 20 && bus2.In_Valid_SI; i++) begin
        bus2.Out_Ready_SI = ($urandom_range(0, 2) != 0);
        tick();
        if (fired2) bus2.In_Valid_SI = 1'b0;
      end
      chk("rnd_accepted", bus2.In_Valid_SI, 0);
    end
    bus2.Out_Ready_SI = 1'b1;
    drain(10);

    // LATENCY=1 full throughput
    lat_chk = 1'b1;
    bus1.Out_Ready_SI = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r64 = {$urandom(), $urandom()};
      r32 = $urandom();
      drive1(r64[W_L-1:0], {16'd0, r32}, r32[W_H-1:0] ^ 27'(k), r32[30], r32[31],
             (k == 3), (k == 7), r32[0], 4'(k + 3));
      tick();
      chk("l1_accept", fired1, 1);
      chk("l1_out_next_cycle", bus1.Out_Valid_SO, 1);
    end
    bus1.In_Valid_SI = 1'b0;
    drain(4);
    chk("l1_idle", bus1.Out_Valid_SO, 0);
    lat_chk = 1'b0;

    // flush with two ops in flight and an input offered in the same cycle
    bus2.Out_Ready_SI = 1'b0;
    drive2(48'd11, 48'd0, 27'd0, 0, 0, 0, 0, 0, 4'd10);
    tick();
    drive2(48'd12, 48'd0, 27'd0, 0, 0, 0, 0, 0, 4'd11);
    tick();
    drive2(48'd13, 48'd0, 27'd0, 0, 0, 0, 0, 0, 4'd12);
    bus2.Flush_SI = 1'b1;
    tick();
    bus2.Flush_SI = 1'b0;
    bus2.In_Valid_SI = 1'b0;
    chk("flush_out_valid", bus2.Out_Valid_SO, 0);
    chk("flush_busy", bus2.Busy_SO, 0);
    chk("flush_in_ready", bus2.In_Ready_SO, 1);
    bus2.Out_Ready_SI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_emit", bus2.Out_Valid_SO, 0);
    end

    // reset with two ops in flight
    bus2.Out_Ready_SI = 1'b0;
    drive2(48'h1234, 48'h55, 27'h7000000, 1, 1, 0, 0, 0, 4'd13);
    tick();
    drive2(48'h99, 48'd1, 27'd0, 0, 1, 0, 0, 0, 4'd14);
    tick();
    bus2.In_Valid_SI = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_zero2("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
